// File: rtl/load_align_unit.sv
// Load alignment stage: issues word-aligned reads, then shifts and extends by funct3.
// Define LOAD_ALIGN_SPLIT_EN to service word-crossing accesses with two reads.
module load_align_unit #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [2:0]        req_funct3_i,
    output logic              mem_read_o,
    output logic [AWIDTH-1:0] mem_address_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_resp_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_data_o,
    output logic              rsp_err_o
);
    localparam int WORD_BYTES = XLEN / 8;
    localparam int OFS_W      = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, RESP} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic              err_q, err_d;
    logic [AWIDTH-1:0] lo_addr;
    logic [OFS_W-1:0]  ofs;
    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   result;
`ifdef LOAD_ALIGN_SPLIT_EN
    logic [AWIDTH-1:0] hi_addr;
`endif

    // Reserved encodings pass the whole shifted word through untouched.
    function automatic logic unsup_f(input logic [2:0] f3);
        return (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
    endfunction

    function automatic logic span_f(input logic [OFS_W-1:0] o, input logic [2:0] f3);
        logic [4:0] size;
        size = unsup_f(f3) ? 5'(WORD_BYTES) : (5'd1 << f3[1:0]);
        return !unsup_f(f3) && ((5'(o) + size) > 5'(WORD_BYTES));
    endfunction

    assign ofs     = addr_q[OFS_W-1:0];
    assign lo_addr = {addr_q[AWIDTH-1:OFS_W], {OFS_W{1'b0}}};
`ifdef LOAD_ALIGN_SPLIT_EN
    assign hi_addr = lo_addr + AWIDTH'(WORD_BYTES);
`endif
    assign shifted = {hi_q, lo_q} >> {ofs, 3'b000};

    always_comb begin
        result = shifted[XLEN-1:0];
        if (!unsup_f(f3_q)) begin
            case (f3_q[1:0])
                2'b00: begin
                    if (f3_q[2]) result = XLEN'(shifted[7:0]);
                    else         result = XLEN'($signed(shifted[7:0]));
                end
                2'b01: begin
                    if (f3_q[2]) result = XLEN'(shifted[15:0]);
                    else         result = XLEN'($signed(shifted[15:0]));
                end
                2'b10: begin
                    if (f3_q[2]) result = XLEN'(shifted[31:0]);
                    else         result = XLEN'($signed(shifted[31:0]));
                end
                default: result = shifted[XLEN-1:0];
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        f3_d          = f3_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        err_d         = err_q;
        req_ready_o   = 1'b0;
        mem_read_o    = 1'b0;
        mem_address_o = '0;
        rsp_valid_o   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    f3_d    = req_funct3_i;
                    err_d   = 1'b0;
                    state_d = RD_LO;
`ifndef LOAD_ALIGN_SPLIT_EN
                    // Crossing access without split support: fail it without touching memory.
                    if (span_f(req_addr_i[OFS_W-1:0], req_funct3_i)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            RD_LO: begin
                mem_read_o    = 1'b1;
                mem_address_o = lo_addr;
                if (mem_resp_i) begin
                    lo_d    = mem_rdata_i;
                    hi_d    = '0;
                    state_d = RESP;
`ifdef LOAD_ALIGN_SPLIT_EN
                    if (span_f(ofs, f3_q)) state_d = RD_HI;
`endif
                end
            end
`ifdef LOAD_ALIGN_SPLIT_EN
            RD_HI: begin
                mem_read_o    = 1'b1;
                mem_address_o = hi_addr;
                if (mem_resp_i) begin
                    hi_d    = mem_rdata_i;
                    state_d = RESP;
                end
            end
`endif
            RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_data_o = (state_q == RESP && !err_q) ? result : '0;
    assign rsp_err_o  = (state_q == RESP) && err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one XLEN=32 and one XLEN=64 instance, each with a small memory model.
module tb_load_align_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // XLEN=32 instance
    logic        rv32 = 1'b0, rr32, mr32, mresp32, rspv32, rspe32;
    logic [31:0] ra32 = '0, maddr32, mrd32, rspd32;
    logic [2:0]  rf32 = '0;

    load_align_unit #(.XLEN(32), .AWIDTH(32)) u32 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(rv32), .req_ready_o(rr32), .req_addr_i(ra32), .req_funct3_i(rf32),
        .mem_read_o(mr32), .mem_address_o(maddr32), .mem_rdata_i(mrd32), .mem_resp_i(mresp32),
        .rsp_valid_o(rspv32), .rsp_data_o(rspd32), .rsp_err_o(rspe32)
    );

    logic [31:0] a32_0 = '0, a32_1 = '0, d32_0 = '0, d32_1 = '0;
    logic [31:0] log32 [16];
    int          cnt32 = 0, wait32 = 0, nrd32 = 0, nmr32 = 0, nrsp32 = 0;
    logic        stale32 = 1'b0;

    assign mrd32   = (maddr32 == a32_1) ? d32_1 : (maddr32 == a32_0) ? d32_0 : 32'hDEADBEEF;
    assign mresp32 = (mr32 && (cnt32 == wait32)) || stale32;

    always @(posedge clk) begin
        if (mr32 && !mresp32) cnt32 <= cnt32 + 1;
        else                  cnt32 <= 0;
        if (mr32) nmr32 <= nmr32 + 1;
        if (mr32 && mresp32) begin
            log32[nrd32 % 16] <= maddr32;
            nrd32 <= nrd32 + 1;
        end
        if (rspv32) nrsp32 <= nrsp32 + 1;
    end

    // XLEN=64 instance
    logic        rv64 = 1'b0, rr64, mr64, mresp64, rspv64, rspe64;
    logic [31:0] ra64 = '0, maddr64;
    logic [63:0] mrd64, rspd64;
    logic [2:0]  rf64 = '0;

    load_align_unit #(.XLEN(64), .AWIDTH(32)) u64 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(rv64), .req_ready_o(rr64), .req_addr_i(ra64), .req_funct3_i(rf64),
        .mem_read_o(mr64), .mem_address_o(maddr64), .mem_rdata_i(mrd64), .mem_resp_i(mresp64),
        .rsp_valid_o(rspv64), .rsp_data_o(rspd64), .rsp_err_o(rspe64)
    );

    logic [31:0] a64_0 = '0, a64_1 = '0;
    logic [63:0] d64_0 = '0, d64_1 = '0;
    logic [31:0] log64 [16];
    int          cnt64 = 0, wait64 = 0, nrd64 = 0, nmr64 = 0, nrsp64 = 0;

    assign mrd64   = (maddr64 == a64_1) ? d64_1 : (maddr64 == a64_0) ? d64_0 : 64'hDEADBEEF_DEADBEEF;
    assign mresp64 = mr64 && (cnt64 == wait64);

    always @(posedge clk) begin
        if (mr64 && !mresp64) cnt64 <= cnt64 + 1;
        else                  cnt64 <= 0;
        if (mr64) nmr64 <= nmr64 + 1;
        if (mr64 && mresp64) begin
            log64[nrd64 % 16] <= maddr64;
            nrd64 <= nrd64 + 1;
        end
        if (rspv64) nrsp64 <= nrsp64 + 1;
    end

    // Issue one request; lat counts negedges after the accept edge until rsp_valid (-1 on timeout).
    task automatic load32(input logic [31:0] a, input logic [2:0] f3,
                          output logic [31:0] d, output logic e, output int lat);
        @(negedge clk);
        rv32 = 1'b1; ra32 = a; rf32 = f3;
        @(posedge clk); #1;
        rv32 = 1'b0;
        lat = -1; d = 'x; e = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rspv32) begin lat = k; d = rspd32; e = rspe32; break; end
        end
    endtask

    task automatic load64(input logic [31:0] a, input logic [2:0] f3,
                          output logic [63:0] d, output logic e, output int lat);
        @(negedge clk);
        rv64 = 1'b1; ra64 = a; rf64 = f3;
        @(posedge clk); #1;
        rv64 = 1'b0;
        lat = -1; d = 'x; e = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rspv64) begin lat = k; d = rspd64; e = rspe64; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (rr32 !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", rr32); end
        total++; if (mr32 !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%b exp=0", mr32); end
        total++; if (maddr32 !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", maddr32); end
        total++; if (rspv32 !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rspv32); end
        total++; if (rspd32 !== 32'h0) begin bad++; $display("FAIL rst_rsp_data got=%h exp=0", rspd32); end
        total++; if (rspe32 !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", rspe32); end
        total++; if (rr64 !== 1'b1 || mr64 !== 1'b0 || rspd64 !== 64'h0)
            begin bad++; $display("FAIL rst_64 got ready=%b read=%b data=%h exp 1/0/0", rr64, mr64, rspd64); end
    endtask

    task automatic test_byte;
        logic [31:0] d; logic e; int lat; int n0;
        a32_0 = 32'h100; d32_0 = 32'h80FF_1234; a32_1 = 32'h0; d32_1 = 32'h0;
        n0 = nrd32;
        load32(32'h103, 3'b000, d, e, lat);
        total++; if (d !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", d); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL lb_err got=%b exp=0", e); end
        total++; if (lat !== 2) begin bad++; $display("FAIL lb_latency got=%0d exp=2", lat); end
        total++; if (nrd32 - n0 !== 1) begin bad++; $display("FAIL lb_reads got=%0d exp=1", nrd32 - n0); end
        total++; if (log32[n0 % 16] !== 32'h100) begin bad++; $display("FAIL lb_addr got=%h exp=100", log32[n0 % 16]); end
        load32(32'h101, 3'b100, d, e, lat);
        total++; if (d !== 32'h0000_0012) begin bad++; $display("FAIL lbu_data got=%h exp=00000012", d); end
    endtask

    task automatic test_half;
        logic [31:0] d; logic e; int lat;
        d32_0 = 32'hBEEF_0000;
        load32(32'h102, 3'b101, d, e, lat);
        total++; if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_data got=%h exp=0000beef", d); end
        load32(32'h102, 3'b001, d, e, lat);
        total++; if (d !== 32'hFFFF_BEEF) begin bad++; $display("FAIL lh_data got=%h exp=ffffbeef", d); end
    endtask

    task automatic test_unsupported;
        logic [31:0] d; logic e; int lat; int n0;
        d32_0 = 32'h80FF_1234;
        n0 = nrd32;
        load32(32'h102, 3'b111, d, e, lat);
        total++; if (d !== 32'h0000_80FF) begin bad++; $display("FAIL unsup_data got=%h exp=000080ff", d); end
        total++; if (e !== 1'b0 || nrd32 - n0 !== 1)
            begin bad++; $display("FAIL unsup_nosplit got err=%b reads=%0d exp err=0 reads=1", e, nrd32 - n0); end
    endtask

    task automatic test_span32;
        logic [31:0] d; logic e; int lat; int n0; int m0;
        a32_0 = 32'h1FC; d32_0 = 32'hAABB_CCDD;
        a32_1 = 32'h200; d32_1 = 32'h1122_3344;
        n0 = nrd32; m0 = nmr32;
        load32(32'h1FE, 3'b010, d, e, lat);
`ifdef LOAD_ALIGN_SPLIT_EN
        total++; if (d !== 32'h3344_AABB) begin bad++; $display("FAIL span32_data got=%h exp=3344aabb", d); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL span32_err got=%b exp=0", e); end
        total++; if (lat !== 3) begin bad++; $display("FAIL span32_latency got=%0d exp=3", lat); end
        total++; if (nrd32 - n0 !== 2 || log32[n0 % 16] !== 32'h1FC || log32[(n0 + 1) % 16] !== 32'h200)
            begin bad++; $display("FAIL span32_reads got n=%0d a0=%h a1=%h exp 2/1fc/200",
                                  nrd32 - n0, log32[n0 % 16], log32[(n0 + 1) % 16]); end
`else
        total++; if (d !== 32'h0) begin bad++; $display("FAIL span32_data got=%h exp=0", d); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL span32_err got=%b exp=1", e); end
        total++; if (lat !== 1) begin bad++; $display("FAIL span32_latency got=%0d exp=1", lat); end
        total++; if (nmr32 - m0 !== 0) begin bad++; $display("FAIL span32_noread got=%0d exp=0", nmr32 - m0); end
`endif
    endtask

    task automatic test_64;
        logic [63:0] d; logic e; int lat; int n0; int m0; int r0;
        wait64 = 3;
        a64_0 = 32'hFFFF_FFF8; d64_0 = 64'h0123_4567_89AB_CDEF;
        a64_1 = 32'h0000_0000; d64_1 = 64'hFEDC_BA98_7654_3210;
        n0 = nrd64; m0 = nmr64; r0 = nrsp64;
        load64(32'hFFFF_FFFC, 3'b011, d, e, lat);
        @(negedge clk); @(negedge clk);
        total++; if (nrsp64 - r0 !== 1) begin bad++; $display("FAIL ld_rsp_count got=%0d exp=1", nrsp64 - r0); end
`ifdef LOAD_ALIGN_SPLIT_EN
        total++; if (d !== 64'h7654_3210_0123_4567) begin bad++; $display("FAIL ld_data got=%h exp=7654321001234567", d); end
        total++; if (e !== 1'b0 || lat !== 9) begin bad++; $display("FAIL ld_err_lat got err=%b lat=%0d exp 0/9", e, lat); end
        total++; if (nrd64 - n0 !== 2 || log64[n0 % 16] !== 32'hFFFF_FFF8 || log64[(n0 + 1) % 16] !== 32'h0)
            begin bad++; $display("FAIL ld_wrap_reads got n=%0d a0=%h a1=%h exp 2/fffffff8/0",
                                  nrd64 - n0, log64[n0 % 16], log64[(n0 + 1) % 16]); end
`else
        total++; if (d !== 64'h0 || e !== 1'b1) begin bad++; $display("FAIL ld_span_err got data=%h err=%b exp 0/1", d, e); end
        total++; if (lat !== 1 || nmr64 - m0 !== 0)
            begin bad++; $display("FAIL ld_span_noread got lat=%0d reads=%0d exp 1/0", lat, nmr64 - m0); end
`endif
        wait64 = 0;
        a64_0 = 32'h0; d64_0 = 64'h8765_4321_0000_0000;
        a64_1 = 32'h8; d64_1 = 64'h0;
        load64(32'h4, 3'b110, d, e, lat);
        total++; if (d !== 64'h0000_0000_8765_4321) begin bad++; $display("FAIL lwu64_data got=%h exp=0000000087654321", d); end
        total++; if (lat !== 2 || e !== 1'b0) begin bad++; $display("FAIL lwu64_lat got lat=%0d err=%b exp 2/0", lat, e); end
        load64(32'h4, 3'b010, d, e, lat);
        total++; if (d !== 64'hFFFF_FFFF_8765_4321) begin bad++; $display("FAIL lw64_data got=%h exp=ffffffff87654321", d); end
        load64(32'h7, 3'b000, d, e, lat);
        total++; if (d !== 64'hFFFF_FFFF_FFFF_FF87) begin bad++; $display("FAIL lb64_data got=%h exp=ffffffffffffff87", d); end
    endtask

    task automatic test_reset_mid;
        int r0;
        wait32 = 1000;
        a32_0 = 32'h100; d32_0 = 32'h1234_5678;
        r0 = nrsp32;
        @(negedge clk);
        rv32 = 1'b1; ra32 = 32'h100; rf32 = 3'b000;
        @(posedge clk); #1;
        rv32 = 1'b0;
        @(negedge clk);
        total++; if (mr32 !== 1'b1) begin bad++; $display("FAIL mid_read_hi got=%b exp=1", mr32); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (mr32 !== 1'b0 || rr32 !== 1'b1 || maddr32 !== 32'h0)
            begin bad++; $display("FAIL mid_abort got read=%b ready=%b addr=%h exp 0/1/0", mr32, rr32, maddr32); end
        stale32 = 1'b1;
        @(negedge clk);
        stale32 = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (nrsp32 - r0 !== 0 || rr32 !== 1'b1)
            begin bad++; $display("FAIL mid_stale got rsp=%0d ready=%b exp 0/1", nrsp32 - r0, rr32); end
        wait32 = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_byte;
        test_half;
        test_unsupported;
        test_span32;
        test_64;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
